// File: rtl/key_schedule_ctrl_pkg.sv
// Shared constants and types for the PRESENT-80 key schedule controller.
// Holds key/round-key sizes, round-key count, index width, the controller
// state type and the 4-bit PRESENT S-box.
package key_schedule_ctrl_pkg;

  localparam int unsigned KEY_SIZE = 80;
  localparam int unsigned RK_SIZE  = 64;
  localparam int unsigned NUM_RK   = 32;
  localparam int unsigned IDX_W    = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_FINISH
  } state_t;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Handshake/bus bundle of key_schedule_ctrl.
//   start, key_in, abort  : schedule request, user key, cancel
//   rk_out, rk_idx        : current round key and its index
//   rk_valid, rk_ready    : round-key valid/ready handshake
//   busy, done            : activity flag, end-of-schedule pulse
// slave = the controller, master = the requester/consumer.
interface key_schedule_ctrl_if;
  import key_schedule_ctrl_pkg::*;

  logic                start;
  logic [KEY_SIZE-1:0] key_in;
  logic                abort;
  logic [RK_SIZE-1:0]  rk_out;
  logic [IDX_W-1:0]    rk_idx;
  logic                rk_valid;
  logic                rk_ready;
  logic                busy;
  logic                done;

  modport slave (
    input  start, key_in, abort, rk_ready,
    output rk_out, rk_idx, rk_valid, busy, done
  );

  modport master (
    output start, key_in, abort, rk_ready,
    input  rk_out, rk_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/present_key_update.sv
// One round of the PRESENT-80 key update (combinational).
//   key     : current 80-bit key register
//   rc      : 5-bit round counter
//   key_nxt : updated key
// Steps: rotate left by 61, S-box on the top nibble, XOR counter into [19:15].
module present_key_update
  import key_schedule_ctrl_pkg::*;
(
  input  logic [KEY_SIZE-1:0] key,
  input  logic [IDX_W-1:0]    rc,
  output logic [KEY_SIZE-1:0] key_nxt
);

  logic [KEY_SIZE-1:0] rot;

  always_comb begin
    rot            = {key[18:0], key[79:19]};
    key_nxt        = rot;
    key_nxt[79:76] = SBOX[rot[79:76]];
    key_nxt[19:15] = rot[19:15] ^ rc;
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// PRESENT-80 key schedule controller.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : key_schedule_ctrl_if.slave (start/key_in/abort in, round keys out
//         with rk_valid/rk_ready handshake, busy and done status)
// Emits round keys K1..K32 (rk_idx 0..31), one per accepted handshake.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  key_schedule_ctrl_if.slave  bus
);

  state_t              state;
  logic [KEY_SIZE-1:0] key_reg;
  logic [KEY_SIZE-1:0] key_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    rc;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  // idx never exceeds 30 when the update is applied, so rc cannot wrap.
  assign rc = idx + 5'd1;

  present_key_update u_upd (
    .key     (key_reg),
    .rc      (rc),
    .key_nxt (key_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      key_reg <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            key_reg <= bus.key_in;
            idx     <= '0;
            busy_q  <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            valid_q <= 1'b1;
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // abort takes priority: a handshake in the same cycle is dropped
          if (bus.abort) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (bus.rk_ready) begin
            if (idx == LAST_IDX) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= ST_FINISH;
            end else begin
              key_reg <= key_nxt;
              idx     <= idx + 5'd1;
            end
          end
        end
        ST_FINISH: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rk_out   = key_reg[79:16];
  assign bus.rk_idx   = idx;
  assign bus.rk_valid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new schedule using key_in; sampled only in IDLE.
REQ-004 SHALL have port key_in, input, 80 bits (`key_size`): user key; captured on an accepted start.
REQ-005 SHALL have port abort, input, 1 bit: cancel an in-progress schedule.
REQ-006 SHALL have port rk_out, output, 64 bits: current round key, equal to key register bits [79:16].
REQ-007 SHALL have port rk_idx, output, 5 bits: index 0..31 of rk_out (round key K(idx+1)).
REQ-008 SHALL have port rk_valid, output, 1 bit: rk_out/rk_idx valid.
REQ-009 SHALL have port rk_ready, input, 1 bit: consumer accepts the round key when rk_valid && rk_ready.
REQ-010 SHALL have port busy, output, 1 bit: high in the LOAD and EMIT states.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after round key 31 is accepted.

Function
REQ-012 SHALL implement the states IDLE, LOAD, EMIT and FINISH.
REQ-013 IDLE: start=1 SHALL capture key_in into the 80-bit key register, clear the index to 0, and go to LOAD.
REQ-014 LOAD SHALL last exactly one cycle and then go to EMIT; the first rk_valid SHALL occur 2 cycles after start is sampled.
REQ-015 EMIT SHALL hold rk_valid=1.
- rk_out and rk_idx SHALL stay stable while rk_ready=0; there is no timeout.
REQ-016 On acceptance in EMIT with idx<31:
- key register <= one-round update of key, using round counter idx+1 (5-bit);
- idx <= idx+1;
- rk_valid SHALL stay high, giving back-to-back throughput of one key per cycle.
REQ-017 The one-round update SHALL apply these steps in order:
- rotate left by 61;
- bits [79:76] <= S-box of the rotated bits [79:76];
- bits [19:15] <= bits [19:15] XOR round counter.
REQ-018 On acceptance with idx=31, the block SHALL go to FINISH with no key update.
REQ-019 FINISH SHALL assert done for one cycle, deassert rk_valid and busy, and return to IDLE.
REQ-020 start while busy or in FINISH SHALL be ignored (no capture, no queuing).
REQ-021 abort=1 in LOAD or EMIT SHALL go to IDLE on the next edge.
- No done pulse.
- rk_valid low the next cycle.
- A handshake completing in the same cycle as abort SHALL be discarded.
REQ-022 abort SHALL be ignored in IDLE and FINISH.
- Simultaneous start and abort in IDLE SHALL start the schedule.
REQ-023 The round counter SHALL never wrap inside a schedule; counter value 31 is the last one applied (K31 to K32).
REQ-024 rk_out SHALL be driven from registers only, with no combinational path from rk_ready.

Reset
REQ-025 rst=0 SHALL asynchronously force the following, regardless of the current state, including mid-schedule:
- state=IDLE;
- key register=0, rk_out=0, rk_idx=0;
- rk_valid=0, busy=0, done=0.
REQ-026 After rst deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-027 The shared constants package SHALL hold:
- key size (80), round-key size (64), number of round keys (32), index width (5);
- the state enum typedef;
- the 4-bit S-box table.
REQ-028 The one-round update SHALL be a combinational sub-module named present_key_update.
- Inputs: 80-bit key and 5-bit counter; output: 80-bit key.
- Instantiated once.
REQ-029 The controller FSM, index counter and key register SHALL reside in key_schedule_ctrl.

Verification
REQ-030 Zero key, start, rk_ready=1 constantly:
- idx0=0x0000000000000000, idx1=0xC000000000000000, idx2=0x5000180000000001;
- 32 keys on consecutive cycles, then a done pulse.
REQ-031 Backpressure: rk_ready=0 for 5 cycles at idx=3; rk_out and rk_idx SHALL stay stable; the sequence SHALL resume identical to the REQ-030 run.
REQ-032 start pulsed at idx=10 with a different key_in: the sequence SHALL be unaffected and key_in ignored.
REQ-033 abort at idx=7 with a simultaneous handshake:
- next cycle rk_valid=0, busy=0, no done;
- a fresh start SHALL reproduce idx0 of its key.
REQ-034 rst asserted asynchronously mid-cycle at idx=20: all outputs SHALL be 0 immediately, and state IDLE.
REQ-035 Key 0xFFFFFFFFFFFFFFFFFFFF: done SHALL pulse exactly once after 32 accepts, and rk_idx SHALL count 0..31 without gaps.
